reg_readback: RTL and testbench
===============================

REG_READBACK -- requirements
Module: reg_readback

Interface
REQ-001 Parameter NUM_REGS, default 4, is the number of 8-bit registers in the snapshot bank.
REQ-002 Parameter WIDTH, default 8, is the bit width of each register and of rd_data.
REQ-003 clk  input  1  is the single clock; every flop updates on its rising edge.
REQ-004 reset  input  1  is the asynchronous, active-low reset; the block is in reset while it is 0.
REQ-005 start  input  1  is a single-cycle request to snapshot and read out the bank.
REQ-006 sel_mask  input  NUM_REGS  selects which registers to read out; bit i selects register i.
REQ-007 reg_bank_in  input  NUM_REGS*WIDTH  carries the live register outputs; register i sits at bits [i*WIDTH +: WIDTH].
REQ-008 abort  input  1  is a synchronous cancel of a readout in progress.
REQ-009 rd_data  output  WIDTH  is the byte currently presented.
REQ-010 rd_idx  output  clog2(NUM_REGS)  is the register index of rd_data.
REQ-011 rd_valid  output  1  means rd_data and rd_idx are valid.
REQ-012 rd_ready  input  1  is the consumer accept signal.
REQ-013 rd_last  output  1  marks the final beat of a readout.
REQ-014 busy  output  1  is high from the cycle after an accepted start until the block returns to IDLE.
REQ-015 done  output  1  is a one-cycle completion pulse.

Function
REQ-016 FSM states shall be IDLE, SEND and DONE; all outputs shall be registered.
REQ-017 In IDLE, start=1 with sel_mask!=0 shall, on that edge, capture reg_bank_in and sel_mask into shadow registers, load rd_idx with the lowest set mask bit, and enter SEND.
REQ-018 In IDLE, start=1 with sel_mask==0 shall stay in IDLE, keep rd_valid=0, and pulse done for one cycle.
REQ-019 Latency: for a start sampled at edge N, rd_valid shall be 1 in the cycle after edge N.
REQ-020 In SEND, rd_valid shall be 1, rd_data shall equal shadow[rd_idx], and rd_last shall be 1 exactly when no higher mask bit above rd_idx is set.
REQ-021 A beat transfers at a rising edge where rd_valid and rd_ready are both 1; after a non-last transfer, rd_idx shall advance to the next higher set mask bit and there shall be no idle cycle between beats.
REQ-022 While rd_valid=1 and rd_ready=0, rd_data, rd_idx and rd_last shall hold stable.
REQ-023 A transfer with rd_last=1 shall clear rd_valid and rd_last and enter DONE.
REQ-024 DONE shall last one cycle with done=1 and busy=1, then return to IDLE.
REQ-025 start shall be ignored in SEND and DONE; changes on reg_bank_in or sel_mask after capture shall not affect the readout in progress.
REQ-026 abort=1 in SEND or DONE shall return the block to IDLE at the next edge with rd_valid, rd_last, busy and done all 0; abort has priority over a simultaneous transfer.
REQ-027 abort=1 in IDLE shall have no effect, and abort has priority over a simultaneous start.
REQ-028 The number of beats per readout shall equal popcount(sel_mask), with indices ascending.

Reset
REQ-029 When reset=0, the FSM shall be IDLE and rd_data, rd_idx, rd_valid, rd_last, busy, done and all shadow registers shall be 0, immediately and without waiting for clk.
REQ-030 Reset asserted mid-readout shall discard the readout, with no done pulse.
REQ-031 After reset deasserts, the first start is accepted at the first rising edge.

Structure
REQ-032 Package reg_readback_pkg shall hold the state enum (IDLE, SEND, DONE) and the NUM_REGS and WIDTH defaults.
REQ-033 One combinational sub-module, next_set_bit, shall return the lowest mask bit above a given index plus a found flag, and the FSM shall use it both to pick the first index and to advance.

Verification
REQ-034 Reset test: with reset=0 asserted mid-SEND, every output shall be 0 asynchronously; after release, start with mask=4'b0001 and bank byte 0 = 8'hA5 -> one beat with rd_data=8'hA5, rd_idx=0, rd_last=1, then done.
REQ-035 Sparse-mask test: mask=4'b1010, bank={8'h44,8'h33,8'h22,8'h11}, rd_ready=1 -> beats (idx1, 8'h22) then (idx3, 8'h44, last) in consecutive cycles, done one cycle later.
REQ-036 Backpressure test: mask=4'b1111 with rd_ready toggling 0,0,1 -> each beat held stable while stalled, 4 beats delivered in order 8'h11, 8'h22, 8'h33, 8'h44.
REQ-037 Snapshot test: after start, change reg_bank_in to all 8'hFF and pulse start again mid-readout -> the original captured values are delivered and exactly one readout occurs.
REQ-038 Abort test: abort together with an accepted beat 2 of 4 -> IDLE next cycle, no done pulse; a new start then behaves normally.
REQ-039 Empty-mask test: start with mask=0 -> done pulses one cycle, rd_valid never rises, busy stays 0.

Source files
------------

// File: rtl/reg_readback_pkg.sv
// reg_readback_pkg: shared state encoding and bank size defaults for reg_readback
package reg_readback_pkg;
  localparam int NUM_REGS_DEF = 4;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
endpackage

// File: rtl/next_set_bit.sv
// next_set_bit: lowest set mask bit at or above 0 (first) or strictly above from
module next_set_bit
  import reg_readback_pkg::*;
#(
  parameter int N = NUM_REGS_DEF,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] from,
  input  logic          first,
  output logic [IW-1:0] idx,
  output logic          found
);
  // scan downwards so the lowest qualifying bit is the one left standing
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (mask[i] && (first || i > int'(from))) begin
        idx = IW'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/reg_readback.sv
// reg_readback: snapshot a register bank and stream the selected bytes out
module reg_readback
  import reg_readback_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_REGS-1:0]       sel_mask,
  input  logic [NUM_REGS*WIDTH-1:0] reg_bank_in,
  input  logic                      abort,
  input  logic                      rd_ready,
  output logic [WIDTH-1:0]          rd_data,
  output logic [IW-1:0]             rd_idx,
  output logic                      rd_valid,
  output logic                      rd_last,
  output logic                      busy,
  output logic                      done
);
  state_t state, state_d;
  logic [NUM_REGS*WIDTH-1:0] bank_sh, src;
  logic [NUM_REGS-1:0] mask_sh, m;
  logic [IW-1:0] n_idx, idx_d;
  logic [WIDTH-1:0] data_d;
  logic n_found, first, cap, tail, valid_d, last_d, busy_d, done_d;
  // in IDLE look at the live inputs so the first beat is ready right after capture
  assign first = state == IDLE;
  assign m = first ? sel_mask : mask_sh;
  assign src = first ? reg_bank_in : bank_sh;
  assign cap = first && start && !abort && n_found;
  // the chosen bit is set, so nothing above it means the shifted mask is exactly 1
  assign tail = (m >> n_idx) == NUM_REGS'(1);
  next_set_bit #(.N(NUM_REGS)) u_nsb (
    .mask(m),
    .from(rd_idx),
    .first(first),
    .idx(n_idx),
    .found(n_found)
  );
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  // next state: abort wins over start and over a simultaneous transfer
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = cap ? SEND : IDLE;
      SEND: state_d = abort ? IDLE : (rd_ready && rd_last) ? DONE : SEND;
      default: state_d = IDLE;
    endcase
  end
  // next values of the registered outputs; hold unless something happens
  always_comb begin
    idx_d = rd_idx;
    data_d = rd_data;
    valid_d = rd_valid;
    last_d = rd_last;
    busy_d = busy;
    done_d = 1'b0;
    case (state)
      IDLE: begin
        done_d = start && !abort && !n_found;
        if (cap) begin
          idx_d = n_idx;
          data_d = src[n_idx*WIDTH +: WIDTH];
          valid_d = 1'b1;
          last_d = tail;
          busy_d = 1'b1;
        end
      end
      SEND:
        if (abort) begin
          valid_d = 1'b0;
          last_d = 1'b0;
          busy_d = 1'b0;
        end else if (rd_ready && rd_last) begin
          valid_d = 1'b0;
          last_d = 1'b0;
          done_d = 1'b1;
        end else if (rd_ready) begin
          idx_d = n_idx;
          data_d = src[n_idx*WIDTH +: WIDTH];
          last_d = tail;
        end
      default: begin
        valid_d = 1'b0;
        last_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end
  // shadow copy taken only when a readout is accepted
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bank_sh <= '0;
      mask_sh <= '0;
    end else if (cap) begin
      bank_sh <= reg_bank_in;
      mask_sh <= sel_mask;
    end
  // output registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_data <= '0;
      rd_idx <= '0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      rd_data <= data_d;
      rd_idx <= idx_d;
      rd_valid <= valid_d;
      rd_last <= last_d;
      busy <= busy_d;
      done <= done_d;
    end
endmodule

// File: tb/tb_reg_readback.sv
// tb_reg_readback: directed and random readouts checked against a mask-walk model
module tb_reg_readback;
  import reg_readback_pkg::*;
  localparam int N = NUM_REGS_DEF;
  localparam int W = WIDTH_DEF;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic rd_ready = 1'b0;
  logic [N-1:0] sel_mask = '0;
  logic [N*W-1:0] reg_bank_in = '0;
  logic [W-1:0] rd_data;
  logic [1:0] rd_idx;
  logic rd_valid, rd_last, busy, done;
  int vectors = 0;
  int errs = 0;

  reg_readback dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .sel_mask(sel_mask),
    .reg_bank_in(reg_bank_in),
    .abort(abort),
    .rd_ready(rd_ready),
    .rd_data(rd_data),
    .rd_idx(rd_idx),
    .rd_valid(rd_valid),
    .rd_last(rd_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag, input logic exp_done);
    chk({tag, "_valid"}, 32'(rd_valid), 0);
    chk({tag, "_last"}, 32'(rd_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
  endtask

  task automatic chk_zero(input string tag);
    chk_quiet(tag, 1'b0);
    chk({tag, "_data"}, 32'(rd_data), 0);
    chk({tag, "_idx"}, 32'(rd_idx), 0);
  endtask

  // model: beats are the set mask bits in ascending order with the captured bytes
  task automatic readout(input logic [N-1:0] m, input logic [N*W-1:0] b, input int mode, input bit disturb);
    int qi[$];
    logic [W-1:0] qd[$];
    int cyc = 0;
    bit rdy;
    for (int i = 0; i < N; i++)
      if (m[i]) begin
        qi.push_back(i);
        qd.push_back(b[i*W +: W]);
      end
    sel_mask = m;
    reg_bank_in = b;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("latency_busy", 32'(busy), 1);
    for (int k = 0; k < qi.size(); k++) begin
      do begin
        rdy = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 2) : 1'($urandom);
        cyc++;
        rd_ready = rdy;
        if (disturb) begin
          reg_bank_in = '1;
          sel_mask = N'($urandom);
          start = 1'($urandom);
        end
        chk("beat_valid", 32'(rd_valid), 1);
        chk("beat_idx", 32'(rd_idx), qi[k]);
        chk("beat_data", 32'(rd_data), 32'(qd[k]));
        chk("beat_last", 32'(rd_last), 32'(k == qi.size() - 1));
        chk("beat_busy", 32'(busy), 1);
        chk("beat_done", 32'(done), 0);
        tick;
      end while (!rdy);
    end
    rd_ready = 1'b0;
    start = disturb;
    chk("end_valid", 32'(rd_valid), 0);
    chk("end_last", 32'(rd_last), 0);
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 1);
    tick;
    start = 1'b0;
    chk_quiet("idle_after", 1'b0);
  endtask

  task automatic empty_start;
    sel_mask = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk_quiet("empty", 1'b1);
    tick;
    chk_quiet("empty_after", 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rm;
    #1;
    chk_zero("reset_async");
    tick;
    chk_zero("reset_held");
    reset = 1'b1;
    readout(4'b1010, 32'h44332211, 0, 1'b0);
    readout(4'b1111, 32'h44332211, 1, 1'b0);
    readout(4'b1111, 32'h44332211, 0, 1'b1);
    empty_start;
    sel_mask = 4'b1111;
    reg_bank_in = 32'h44332211;
    start = 1'b1;
    tick;
    start = 1'b0;
    rd_ready = 1'b1;
    chk("abort_beat1_idx", 32'(rd_idx), 0);
    tick;
    chk("abort_beat2_idx", 32'(rd_idx), 1);
    chk("abort_beat2_data", 32'(rd_data), 32'h22);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    rd_ready = 1'b0;
    chk_quiet("abort_idle", 1'b0);
    tick;
    chk_quiet("abort_nodone", 1'b0);
    readout(4'b0110, 32'h44332211, 0, 1'b0);
    abort = 1'b1;
    start = 1'b1;
    tick;
    abort = 1'b0;
    start = 1'b0;
    chk_quiet("abort_start", 1'b0);
    tick;
    chk_quiet("abort_start_after", 1'b0);
    sel_mask = 4'b1111;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("pre_reset_valid", 32'(rd_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk_zero("reset_mid");
    tick;
    chk_zero("reset_mid_held");
    reset = 1'b1;
    readout(4'b0001, 32'h000000A5, 0, 1'b0);
    for (int t = 0; t < 40; t++) begin
      rm = N'($urandom);
      if (rm == 0) empty_start;
      else readout(rm, $urandom, 2, 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
